uart_cmd_ctrl: RTL

- Parametrised successor to the fixed UART command decoder.
- Parses framed UART packets (opcode, multi-byte address, length, payload) into SDRAM write/read requests carrying address and burst length.
- Streams write payload into the write FIFO and paces UART transmit from the read FIFO, replacing the ad-hoc combinational tx trigger.
- Sits between uart_rx/uart_tx, the two FIFOs and sdram_top.

---
 rtl/uart_cmd_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command frame parser, SDRAM request issuer and UART TX pacer
//
// Frame format: opcode, ADDR_BYTES address bytes (MSB first), one length byte,
// then (writes only) length payload bytes.
//
// Ports:
//   sclk, reset             clock, asynchronous active-low reset
//   uart_flag, uart_data    received byte strobe and value
//   wfifo_wr_en, wfifo_data payload push into the write FIFO (1-cycle latency)
//   wfifo_full              write FIFO full; payload bytes are dropped and ovf set
//   sdram_busy              SDRAM controller busy; requests wait while high
//   wr_trig, rd_trig        one-cycle SDRAM requests
//   cmd_addr, cmd_len       request address/length, held until the next frame's length byte
//   rfifo_empty, rfifo_wr_en read FIFO status used by the TX pacer
//   tx_busy, tx_trig        uart_tx status and start pulse
//   frm_err                 one-cycle pulse on zero length or mid-frame timeout
//   ovf                     sticky payload-drop flag, cleared only by reset
module uart_cmd_ctrl #(
  parameter int              DATA_W      = 8,
  parameter int              ADDR_BYTES  = 3,
  parameter int              LEN_W       = 8,
  parameter int              TIMEOUT_CYC = 50000,
  parameter logic [DATA_W-1:0] OP_WR     = 8'h55,
  parameter logic [DATA_W-1:0] OP_RD     = 8'hAA
) (
  input  logic                    sclk,
  input  logic                    reset,
  input  logic                    uart_flag,
  input  logic [DATA_W-1:0]       uart_data,
  output logic                    wfifo_wr_en,
  output logic [DATA_W-1:0]       wfifo_data,
  input  logic                    wfifo_full,
  input  logic                    sdram_busy,
  output logic                    wr_trig,
  output logic                    rd_trig,
  output logic [8*ADDR_BYTES-1:0] cmd_addr,
  output logic [LEN_W-1:0]        cmd_len,
  input  logic                    rfifo_empty,
  input  logic                    rfifo_wr_en,
  input  logic                    tx_busy,
  output logic                    tx_trig,
  output logic                    frm_err,
  output logic                    ovf
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_ISSUE_WR, S_ISSUE_RD
  } state_t;

  state_t            state;
  logic              op_rd;
  logic [2:0]        byte_cnt;
  logic [AW-1:0]     addr_sh;
  logic [LEN_W-1:0]  remaining;
  logic [TW-1:0]     silence_cnt;
  logic [LEN_W-1:0]  len_byte;
  logic              tx_hist1;
  logic              tx_hist2;

  assign len_byte = LEN_W'(uart_data);

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      op_rd       <= 1'b0;
      byte_cnt    <= '0;
      addr_sh     <= '0;
      remaining   <= '0;
      silence_cnt <= '0;
      wfifo_wr_en <= 1'b0;
      wfifo_data  <= '0;
      wr_trig     <= 1'b0;
      rd_trig     <= 1'b0;
      cmd_addr    <= '0;
      cmd_len     <= '0;
      frm_err     <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      wfifo_wr_en <= 1'b0;
      wr_trig     <= 1'b0;
      rd_trig     <= 1'b0;
      frm_err     <= 1'b0;
      case (state)
        S_IDLE: begin
          silence_cnt <= '0;
          if (uart_flag && (uart_data == OP_WR || uart_data == OP_RD)) begin
            op_rd    <= (uart_data == OP_RD);
            byte_cnt <= '0;
            state    <= S_ADDR;
          end
        end
        S_ADDR, S_LEN, S_DATA: begin
          if (uart_flag) begin
            // A byte always beats a timeout expiring in the same cycle.
            silence_cnt <= '0;
            case (state)
              S_ADDR: begin
                addr_sh  <= (addr_sh << 8) | AW'(uart_data[7:0]);
                byte_cnt <= byte_cnt + 3'd1;
                if (byte_cnt == 3'(ADDR_BYTES - 1)) state <= S_LEN;
              end
              S_LEN: begin
                if (len_byte == '0) begin
                  frm_err <= 1'b1;
                  state   <= S_IDLE;
                end else begin
                  // Previous request's address/length stay visible until here.
                  cmd_addr  <= addr_sh;
                  cmd_len   <= len_byte;
                  remaining <= len_byte;
                  state     <= op_rd ? S_ISSUE_RD : S_DATA;
                end
              end
              default: begin
                if (wfifo_full) begin
                  ovf <= 1'b1;
                end else begin
                  wfifo_wr_en <= 1'b1;
                  wfifo_data  <= uart_data;
                end
                remaining <= remaining - LEN_W'(1);
                if (remaining == LEN_W'(1)) state <= S_ISSUE_WR;
              end
            endcase
          end else if (silence_cnt == TW'(TIMEOUT_CYC - 1)) begin
            frm_err <= 1'b1;
            state   <= S_IDLE;
          end else begin
            silence_cnt <= silence_cnt + TW'(1);
          end
        end
        S_ISSUE_WR: begin
          if (!sdram_busy) begin
            wr_trig <= 1'b1;
            state   <= S_IDLE;
          end
        end
        S_ISSUE_RD: begin
          if (!sdram_busy) begin
            rd_trig <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // TX pacer: the two-cycle history guard covers the delay before uart_tx
  // raises tx_busy after a start pulse, so one byte never gets two starts.
  assign tx_trig = reset && !rfifo_empty && !tx_busy && !rfifo_wr_en
                   && !tx_hist1 && !tx_hist2;

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      tx_hist1 <= 1'b0;
      tx_hist2 <= 1'b0;
    end else begin
      tx_hist1 <= tx_trig;
      tx_hist2 <= tx_hist1;
    end
  end

endmodule
